// File: rtl/kme_ob_capture_if.sv
// Outbound KME AXI-stream bundle between cr_kme (master) and kme_ob_capture (slave).
// Field widths come from the AXI_S_* macros; defaults apply when the build does not set them.
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 4
`endif
`ifndef AXI_S_TSTRB_WIDTH
`define AXI_S_TSTRB_WIDTH 8
`endif
`ifndef AXI_S_USER_WIDTH
`define AXI_S_USER_WIDTH 4
`endif

interface kme_ob_capture_if;
    logic                          kme_ob_tvalid;
    logic                          kme_ob_tready;
    logic [`AXI_S_DP_DWIDTH-1:0]   kme_ob_tdata;
    logic [`AXI_S_TID_WIDTH-1:0]   kme_ob_tid;
    logic [`AXI_S_TSTRB_WIDTH-1:0] kme_ob_tstrb;
    logic [`AXI_S_USER_WIDTH-1:0]  kme_ob_tuser;
    logic                          kme_ob_tlast;

    modport master (
        output kme_ob_tvalid, kme_ob_tdata, kme_ob_tid, kme_ob_tstrb, kme_ob_tuser, kme_ob_tlast,
        input  kme_ob_tready
    );

    modport slave (
        input  kme_ob_tvalid, kme_ob_tdata, kme_ob_tid, kme_ob_tstrb, kme_ob_tuser, kme_ob_tlast,
        output kme_ob_tready
    );
endinterface

// File: rtl/kme_ob_capture.sv
// Sink for the KME outbound stream: FWFT capture FIFO, frame counters and protocol checker.
// Optional LFSR backpressure is enabled by defining KME_OB_THROTTLE_EN.
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 4
`endif
`ifndef AXI_S_TSTRB_WIDTH
`define AXI_S_TSTRB_WIDTH 8
`endif
`ifndef AXI_S_USER_WIDTH
`define AXI_S_USER_WIDTH 4
`endif

module kme_ob_capture #(
    parameter int          DEPTH     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         AW        = $clog2(DEPTH),
    localparam int         BEAT_W    = 1 + `AXI_S_USER_WIDTH + `AXI_S_TID_WIDTH
                                         + `AXI_S_TSTRB_WIDTH + `AXI_S_DP_DWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    kme_ob_capture_if.slave      ob,
    input  logic                 pop_req,
    output logic                 pop_valid,
    output logic [BEAT_W-1:0]    pop_beat,
    output logic [AW:0]          fifo_level,
    output logic [15:0]          frames_pending,
    output logic [15:0]          frame_cnt,
    input  logic [3:0]           throttle_thr,
    input  logic                 clr_err,
    output logic                 proto_err
);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t                      state, state_next;
    logic [AW:0]                 wr_ptr, rd_ptr;
    logic [BEAT_W-1:0]           mem [DEPTH];
    logic [BEAT_W-1:0]           in_beat, head, cap_beat;
    logic [`AXI_S_TID_WIDTH-1:0] tid_q;
    logic                        full, empty, push, pop, pop_last;
    logic                        ready_en, stall, stall_q;
    logic                        tid_err, stall_err;

    assign in_beat = {ob.kme_ob_tlast, ob.kme_ob_tuser, ob.kme_ob_tid,
                      ob.kme_ob_tstrb, ob.kme_ob_tdata};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // ready_en holds tready low until the first edge after reset release.
    assign ob.kme_ob_tready = ready_en & ~full & ~stall;
    assign push             = ob.kme_ob_tvalid & ob.kme_ob_tready;
    assign pop              = pop_req & ~empty;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign pop_valid  = ~empty;
    assign pop_beat   = empty ? '0 : head;
    assign pop_last   = head[BEAT_W-1];
    assign fifo_level = wr_ptr - rd_ptr;

`ifdef KME_OB_THROTTLE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[3:0] < throttle_thr);
`else
    logic unused_thr;
    assign unused_thr = ^throttle_thr;
    assign stall      = 1'b0;
`endif

    // NOTE: storage has no reset; the pointers alone define what is valid, and
    // leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_beat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            frames_pending <= '0;
            frame_cnt      <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push & ob.kme_ob_tlast, pop & pop_last})
                2'b10:   frames_pending <= frames_pending + 16'd1;
                2'b01:   frames_pending <= frames_pending - 16'd1;
                default: frames_pending <= frames_pending;
            endcase
            if (push && ob.kme_ob_tlast && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        tid_err    = 1'b0;
        if (push) begin
            case (state)
                IDLE: begin
                    if (!ob.kme_ob_tlast) state_next = IN_FRAME;
                end
                IN_FRAME: begin
                    if (ob.kme_ob_tid != tid_q) tid_err = 1'b1;
                    if (ob.kme_ob_tlast)        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A stalled beat must reappear unchanged on the next cycle.
    assign stall_err = stall_q & (~ob.kme_ob_tvalid | (in_beat != cap_beat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tid_q     <= '0;
            stall_q   <= 1'b0;
            cap_beat  <= '0;
            proto_err <= 1'b0;
        end else begin
            state    <= state_next;
            if (state == IDLE && push && !ob.kme_ob_tlast) tid_q <= ob.kme_ob_tid;
            stall_q  <= ob.kme_ob_tvalid & ~ob.kme_ob_tready;
            cap_beat <= in_beat;
            if (tid_err || stall_err) proto_err <= 1'b1;
            else if (clr_err)         proto_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kme_ob_capture.sv
// Scoreboard bench for kme_ob_capture: accepted beats are queued and compared at readback.
`ifndef AXI_S_DP_DWIDTH
`define AXI_S_DP_DWIDTH 64
`endif
`ifndef AXI_S_TID_WIDTH
`define AXI_S_TID_WIDTH 4
`endif
`ifndef AXI_S_TSTRB_WIDTH
`define AXI_S_TSTRB_WIDTH 8
`endif
`ifndef AXI_S_USER_WIDTH
`define AXI_S_USER_WIDTH 4
`endif

module tb_kme_ob_capture;
    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);
    localparam int BEAT_W = 1 + `AXI_S_USER_WIDTH + `AXI_S_TID_WIDTH
                              + `AXI_S_TSTRB_WIDTH + `AXI_S_DP_DWIDTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pop_req = 1'b0;
    logic              pop_valid;
    logic [BEAT_W-1:0] pop_beat;
    logic [AW:0]       fifo_level;
    logic [15:0]       frames_pending;
    logic [15:0]       frame_cnt;
    logic [3:0]        throttle_thr = 4'd0;
    logic              clr_err = 1'b0;
    logic              proto_err;

    kme_ob_capture_if bus ();

    kme_ob_capture #(.DEPTH(DEPTH), .LFSR_SEED(16'hACE1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ob             (bus.slave),
        .pop_req        (pop_req),
        .pop_valid      (pop_valid),
        .pop_beat       (pop_beat),
        .fifo_level     (fifo_level),
        .frames_pending (frames_pending),
        .frame_cnt      (frame_cnt),
        .throttle_thr   (throttle_thr),
        .clr_err        (clr_err),
        .proto_err      (proto_err)
    );

    always #5 clk = ~clk;

    int                checks = 0;
    int                failures = 0;
    logic [BEAT_W-1:0] sb_q [$];
    int                exp_frames = 0;
    bit                last_acc;
    int                n_cycles, n_ready;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; evaluates handshakes mid-cycle, returns at next posedge+1.
    task automatic cycle();
        logic [BEAT_W-1:0] exp_beat;
        #4;
        n_cycles++;
        if (bus.kme_ob_tready) n_ready++;
        last_acc = bus.kme_ob_tvalid && bus.kme_ob_tready;
        if (last_acc) begin
            sb_q.push_back({bus.kme_ob_tlast, bus.kme_ob_tuser, bus.kme_ob_tid,
                            bus.kme_ob_tstrb, bus.kme_ob_tdata});
            if (bus.kme_ob_tlast && exp_frames < 65535) exp_frames++;
        end
        if (pop_req && pop_valid) begin
            if (sb_q.size() == 0) begin
                check("pop_underflow", 128'(pop_valid), 128'd0);
            end else begin
                exp_beat = sb_q.pop_front();
                check("pop_beat", 128'(pop_beat), 128'(exp_beat));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input int id, input bit last);
        bus.kme_ob_tvalid = 1'b1;
        bus.kme_ob_tdata  = `AXI_S_DP_DWIDTH'(d);
        bus.kme_ob_tid    = `AXI_S_TID_WIDTH'(id);
        bus.kme_ob_tstrb  = `AXI_S_TSTRB_WIDTH'(d[7:0] ^ 8'hFF);
        bus.kme_ob_tuser  = `AXI_S_USER_WIDTH'(d[3:0] ^ 4'h5);
        bus.kme_ob_tlast  = last;
    endtask

    task automatic send(input logic [63:0] d, input int id, input bit last);
        int n = 0;
        drive(d, id, last);
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 64);
        if (!last_acc) check("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic idle();
        bus.kme_ob_tvalid = 1'b0;
        bus.kme_ob_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        pop_req = 1'b1;
        while (sb_q.size() > 0 && n < 200) begin
            cycle();
            n++;
        end
        pop_req = 1'b0;
        check("drain_sb_empty", 128'(sb_q.size()), 128'd0);
        check("drain_level", 128'(fifo_level), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        bus.kme_ob_tdata = '0;
        bus.kme_ob_tid   = '0;
        bus.kme_ob_tstrb = '0;
        bus.kme_ob_tuser = '0;

        // Reset state, including tready low before the first edge after release.
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        check("rst_tready", 128'(bus.kme_ob_tready), 128'd0);
        check("rst_pop_valid", 128'(pop_valid), 128'd0);
        check("rst_pop_beat", 128'(pop_beat), 128'd0);
        check("rst_level", 128'(fifo_level), 128'd0);
        check("rst_frames_pending", 128'(frames_pending), 128'd0);
        check("rst_frame_cnt", 128'(frame_cnt), 128'd0);
        check("rst_proto_err", 128'(proto_err), 128'd0);
        @(posedge clk);
        #1;
        check("tready_after_rst", 128'(bus.kme_ob_tready), 128'd1);

        // Four-beat frame, tid 2, then readback.
        for (int i = 1; i <= 4; i++) send(64'(i), 2, i == 4);
        idle();
        check("t1_frame_cnt", 128'(frame_cnt), 128'd1);
        check("t1_frames_pending", 128'(frames_pending), 128'd1);
        check("t1_level", 128'(fifo_level), 128'd4);
        drain();
        check("t1_frames_pending_after", 128'(frames_pending), 128'd0);

        // Fill to DEPTH, then free one slot while the next beat waits.
        for (int i = 0; i < DEPTH; i++) send(64'(32 + i), 4, 1'b0);
        drive(64'd99, 4, 1'b1);
        check("t2_tready_full", 128'(bus.kme_ob_tready), 128'd0);
        check("t2_level_full", 128'(fifo_level), 128'(DEPTH));
        pop_req = 1'b1;
        cycle();
        pop_req = 1'b0;
        check("t2_tready_after_pop", 128'(bus.kme_ob_tready), 128'd1);
        cycle();
        check("t2_17th_accepted", 128'(last_acc), 128'd1);
        idle();
        check("t2_level_refill", 128'(fifo_level), 128'(DEPTH));
        check("t2_no_proto_err", 128'(proto_err), 128'd0);
        drain();
        check("t2_frame_cnt", 128'(frame_cnt), 128'(exp_frames));

        // tid changes inside a frame.
        send(64'd10, 2, 1'b0);
        send(64'd11, 3, 1'b0);
        idle();
        check("t3_tid_err", 128'(proto_err), 128'd1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("t3_clr", 128'(proto_err), 128'd0);
        send(64'd12, 2, 1'b1);
        idle();
        drain();

        // Stalled beat altered, then withdrawn.
        for (int i = 0; i < DEPTH; i++) send(64'(100 + i), 5, i == DEPTH - 1);
        drive(64'd200, 5, 1'b1);
        check("t4_tready_full", 128'(bus.kme_ob_tready), 128'd0);
        cycle();
        check("t4_stable_ok", 128'(proto_err), 128'd0);
        drive(64'd201, 5, 1'b1);
        cycle();
        check("t4_data_change_err", 128'(proto_err), 128'd1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("t4_clr", 128'(proto_err), 128'd0);
        idle();
        cycle();
        check("t4_drop_valid_err", 128'(proto_err), 128'd1);
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        check("t4_clr2", 128'(proto_err), 128'd0);
        check("t4_frames_pending", 128'(frames_pending), 128'd1);
        drain();

        // Push of a tlast beat coinciding with pop of a tlast head at level 5.
        send(64'd300, 6, 1'b1);
        for (int i = 1; i <= 4; i++) send(64'(300 + i), 6, 1'b0);
        idle();
        check("t5_level_before", 128'(fifo_level), 128'd5);
        check("t5_fp_before", 128'(frames_pending), 128'd1);
        drive(64'd305, 6, 1'b1);
        pop_req = 1'b1;
        cycle();
        pop_req = 1'b0;
        idle();
        check("t5_push_taken", 128'(last_acc), 128'd1);
        check("t5_level_after", 128'(fifo_level), 128'd5);
        check("t5_fp_after", 128'(frames_pending), 128'd1);
        drain();
        check("t5_fp_drained", 128'(frames_pending), 128'd0);
        check("t5_no_proto_err", 128'(proto_err), 128'd0);

        // Asynchronous reset in the middle of a frame.
        send(64'd400, 7, 1'b0);
        send(64'd401, 7, 1'b0);
        idle();
        rst_n = 1'b0;
        #2;
        check("mid_rst_level", 128'(fifo_level), 128'd0);
        check("mid_rst_pop_valid", 128'(pop_valid), 128'd0);
        check("mid_rst_frame_cnt", 128'(frame_cnt), 128'd0);
        check("mid_rst_tready", 128'(bus.kme_ob_tready), 128'd0);
        sb_q.delete();
        exp_frames = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'd500, 9, 1'b1);
        send(64'd501, 8, 1'b0);
        send(64'd502, 8, 1'b1);
        idle();
        check("post_rst_no_err", 128'(proto_err), 128'd0);
        check("post_rst_frame_cnt", 128'(frame_cnt), 128'(exp_frames));
        drain();

`ifdef KME_OB_THROTTLE_EN
        // Random backpressure at threshold 8 with continuous readback.
        throttle_thr = 4'd8;
        pop_req      = 1'b1;
        n_cycles     = 0;
        n_ready      = 0;
        for (int i = 0; i < 1000; i++) send(64'(1000 + i), 3, (i % 8) == 7);
        idle();
        check("thr8_duty_ok", 128'((n_ready * 100 >= n_cycles * 40) && (n_ready * 100 <= n_cycles * 60)), 128'd1);
        check("thr8_no_err", 128'(proto_err), 128'd0);
        drain();
        throttle_thr = 4'd0;
        n_cycles     = 0;
        n_ready      = 0;
        pop_req      = 1'b1;
        for (int i = 0; i < 50; i++) send(64'(5000 + i), 3, (i % 5) == 4);
        idle();
        check("thr0_always_ready", 128'(n_ready), 128'(n_cycles));
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
